// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one single-port, fixed-latency synchronous word memory between the
//   core's instruction-fetch port (read-only) and its load/store port
//   (read/write with byte strobes). One transaction is in flight at a time:
//   IDLE (grant) -> ISSUE (mem strobe) -> WAIT (latency) -> RESP (pulse).
//   The data port wins contention unless fetch has lost MAX_STARVE times in a
//   row, in which case fetch is forced through.
//
// Handshake: a requester raises *_req and holds its fields stable until the
//   cycle its *_gnt is high. A grant is given only in IDLE, and the fields are
//   latched in that same cycle. The response is a single-cycle *_rsp_valid
//   pulse MEM_LATENCY+2 cycles after the grant. There is no backpressure on
//   the response.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   i_req/i_addr/i_gnt              fetch request, byte address, grant
//   i_rsp_valid/i_rsp_rdata         fetch response pulse and word
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request fields
//   d_gnt                           load/store grant
//   d_rsp_valid/d_rsp_rdata         load data or store ack (rdata 0 on stores)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory access, one cycle
//   mem_rdata                       memory read data, MEM_LATENCY after mem_req
//   busy                            high whenever the FSM is not in IDLE
module rv_mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STARVE  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int WA   = ADDR_W - 2;
  localparam int LATW = 3;
  localparam int SCW  = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;        // 1 = data port owns the transaction
  logic            we_q, we_d;
  logic [WA-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [LATW-1:0] lat_q, lat_d;
  logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            i_gnt_c, d_gnt_c;
  logic            fetch_win;

  // Byte offsets within a word do not reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    lat_d        = lat_q;
    starve_cnt_d = starve_cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_gnt_c      = 1'b0;
    d_gnt_c      = 1'b0;
    fetch_win    = i_req && (!d_req || (starve_cnt_q == SCW'(MAX_STARVE)));
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ISSUE;
          if (fetch_win) begin
            i_gnt_c      = 1'b1;
            owner_d      = 1'b0;
            we_d         = 1'b0;
            addr_d       = i_addr[ADDR_W-1:2];
            wdata_d      = 32'h0;
            wstrb_d      = 4'h0;
            starve_cnt_d = '0;
          end else begin
            d_gnt_c = 1'b1;
            owner_d = 1'b1;
            we_d    = d_we;
            addr_d  = d_addr[ADDR_W-1:2];
            wdata_d = d_we ? d_wdata : 32'h0;
            wstrb_d = d_we ? d_wstrb : 4'h0;
            // Only a loss while fetch is actually waiting counts as starvation.
            if (i_req && (starve_cnt_q != SCW'(MAX_STARVE)))
              starve_cnt_d = starve_cnt_q + SCW'(1);
          end
        end
      end
      ISSUE: begin
        lat_d   = LATW'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          // Response word lands in the owner's register on entry to RESP,
          // so the non-owner's output keeps its previous value.
          if (owner_q) d_rdata_d = we_q ? 32'h0 : mem_rdata;
          else         i_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - LATW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      lat_q        <= '0;
      starve_cnt_q <= '0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      lat_q        <= lat_d;
      starve_cnt_q <= starve_cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Grants are combinational in the request cycle; masking with reset keeps
  // every output low while reset is held even if a request is present.
  assign i_gnt       = i_gnt_c && !reset;
  assign d_gnt       = d_gnt_c && !reset;
  assign mem_req     = (state_q == ISSUE);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = mem_req ? addr_q  : '0;
  assign mem_wdata   = mem_req ? wdata_q : 32'h0;
  assign mem_wstrb   = mem_req ? wstrb_q : 4'h0;
  assign i_rsp_valid = (state_q == RESP) && !owner_q;
  assign d_rsp_valid = (state_q == RESP) && owner_q;
  assign i_rsp_rdata = i_rdata_q;
  assign d_rsp_rdata = d_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance 1: MEM_LATENCY = 1 ----------------
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [9:0]  i_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic [3:0]  d_wstrb = 0;
  logic        i_gnt, i_rsp_valid, d_gnt, d_rsp_valid, mem_req, mem_we, busy;
  logic [31:0] i_rsp_rdata, d_rsp_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;

  rv_mem_arbiter #(.ADDR_W(10), .MEM_LATENCY(1), .MAX_STARVE(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // ---------------- instance 4: MEM_LATENCY = 4 ----------------
  logic        i_req4 = 0, d_req4 = 0, d_we4 = 0;
  logic [9:0]  i_addr4 = 0, d_addr4 = 0;
  logic [31:0] d_wdata4 = 0;
  logic [3:0]  d_wstrb4 = 0;
  logic        i_gnt4, i_rsp_valid4, d_gnt4, d_rsp_valid4, mem_req4, mem_we4, busy4;
  logic [31:0] i_rsp_rdata4, d_rsp_rdata4, mem_wdata4, mem_rdata4;
  logic [7:0]  mem_addr4;
  logic [3:0]  mem_wstrb4;

  rv_mem_arbiter #(.ADDR_W(10), .MEM_LATENCY(4), .MAX_STARVE(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .i_req(i_req4), .i_addr(i_addr4), .i_gnt(i_gnt4),
    .i_rsp_valid(i_rsp_valid4), .i_rsp_rdata(i_rsp_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_wstrb(d_wstrb4), .d_gnt(d_gnt4),
    .d_rsp_valid(d_rsp_valid4), .d_rsp_rdata(d_rsp_rdata4),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_wstrb(mem_wstrb4), .mem_rdata(mem_rdata4),
    .busy(busy4)
  );

  // ---------------- memory models ----------------
  // Outside a valid read slot the read data carries junk, so a sample taken
  // on the wrong cycle shows up as a wrong response word.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem4 [0:255];
  logic [31:0] pipe1;
  logic [31:0] pipe4 [0:3];
  logic [31:0] cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) begin
      pipe1 <= mem1[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem1[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      pipe1 <= 32'hBAD0_0000 | cyc;
    end
    pipe4[0] <= mem_req4 ? mem4[mem_addr4] : (32'h5EED_0000 | cyc);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata4 = pipe4[3];

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_seq [0:7];
  logic [31:0] exp_sv  [0:7];
  int ng, last, pend, cnt, mr, pulses;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem1[k] = 32'h0100_0000 + k;
      mem4[k] = 32'h0400_0000 + k;
    end
    mem1[4]  = 32'hDEADBEEF;
    mem1[8]  = 32'hAAAAAAAA;
    mem4[12] = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) pipe4[k] = 32'h0;
    pipe1 = 32'h0;

    // --- reset state: a pending request must not be granted under reset
    #1;
    i_req = 1; i_addr = 10'h010;
    settle();
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_rdata", i_rsp_rdata, 0);
    chk("rst_d_rdata", d_rsp_rdata, 0);
    step();
    i_req = 0;
    step();
    reset = 0;
    step();

    // --- single fetch, latency 1
    i_req = 1; i_addr = 10'h010;
    settle();
    chk("f_i_gnt_c0", i_gnt, 1);
    chk("f_d_gnt_c0", d_gnt, 0);
    chk("f_busy_c0", busy, 0);
    step(); i_req = 0; settle();
    chk("f_mem_req_c1", mem_req, 1);
    chk("f_mem_addr_c1", mem_addr, 4);
    chk("f_mem_we_c1", mem_we, 0);
    chk("f_mem_wstrb_c1", mem_wstrb, 0);
    chk("f_busy_c1", busy, 1);
    step(); settle();
    chk("f_mem_req_c2", mem_req, 0);
    chk("f_mem_addr_c2", mem_addr, 0);
    chk("f_rsp_c2", i_rsp_valid, 0);
    chk("f_busy_c2", busy, 1);
    step(); settle();
    chk("f_rsp_c3", i_rsp_valid, 1);
    chk("f_rdata_c3", i_rsp_rdata, 32'hDEADBEEF);
    chk("f_drsp_c3", d_rsp_valid, 0);
    chk("f_busy_c3", busy, 1);
    step(); settle();
    chk("f_rsp_c4", i_rsp_valid, 0);
    chk("f_busy_c4", busy, 0);
    chk("f_rdata_hold", i_rsp_rdata, 32'hDEADBEEF);

    // --- store then load
    d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    settle();
    chk("st_d_gnt", d_gnt, 1);
    chk("st_i_gnt", i_gnt, 0);
    step(); d_req = 0; d_we = 0; d_wdata = 0; d_wstrb = 0; settle();
    chk("st_mem_req", mem_req, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wstrb", mem_wstrb, 4'b0011);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);
    chk("st_mem_addr", mem_addr, 8);
    step(); step(); settle();
    chk("st_rsp", d_rsp_valid, 1);
    chk("st_rdata", d_rsp_rdata, 0);
    chk("st_irsp", i_rsp_valid, 0);
    step();
    d_req = 1; d_addr = 10'h022;   // low address bits must be ignored
    settle();
    chk("ld_d_gnt", d_gnt, 1);
    step(); d_req = 0; settle();
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_wstrb", mem_wstrb, 0);
    chk("ld_mem_wdata", mem_wdata, 0);
    chk("ld_mem_addr", mem_addr, 8);
    step(); step(); settle();
    chk("ld_rsp", d_rsp_valid, 1);
    chk("ld_rdata", d_rsp_rdata, 32'hAAAA5678);
    chk("ld_i_rdata_hold", i_rsp_rdata, 32'hDEADBEEF);
    step();

    // --- request while busy: data request raised during a fetch's WAIT
    i_req = 1; i_addr = 10'h010;
    settle();
    chk("rb_i_gnt", i_gnt, 1);
    step(); i_req = 0; settle();
    chk("rb_dgnt_issue", d_gnt, 0);
    step(); d_req = 1; d_addr = 10'h020; settle();
    chk("rb_dgnt_wait", d_gnt, 0);
    step(); settle();
    chk("rb_dgnt_resp", d_gnt, 0);
    chk("rb_irsp", i_rsp_valid, 1);
    step(); settle();
    chk("rb_dgnt_idle", d_gnt, 1);
    chk("rb_busy_idle", busy, 0);
    step(); d_req = 0;
    step(); step(); step();

    // --- contention, MAX_STARVE = 3
    exp_seq[0] = 1; exp_seq[1] = 1; exp_seq[2] = 1; exp_seq[3] = 0;
    exp_seq[4] = 1; exp_seq[5] = 1; exp_seq[6] = 1; exp_seq[7] = 0;
    exp_sv[0] = 1; exp_sv[1] = 2; exp_sv[2] = 3; exp_sv[3] = 0;
    exp_sv[4] = 1; exp_sv[5] = 2; exp_sv[6] = 3; exp_sv[7] = 0;
    i_req = 1; i_addr = 10'h010; d_req = 1; d_we = 0; d_addr = 10'h020;
    ng = 0; last = 0; pend = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      settle();
      if (pend != 0) begin
        chk("starve_cnt", 32'(u_dut1.starve_cnt_q), exp_sv[ng-1]);
        pend = 0;
      end
      chk("gnt_excl", {31'b0, i_gnt & d_gnt}, 0);
      chk("gnt_busy", {31'b0, (i_gnt | d_gnt) & busy}, 0);
      if (i_gnt || d_gnt) begin
        chk("order", {31'b0, d_gnt}, exp_seq[ng]);
        if (ng > 0) chk("spacing", c - last, 4);
        last = c;
        pend = 1;
        ng++;
      end
      step();
    end
    i_req = 0; d_req = 0;
    settle();
    chk("grants", ng, 8);
    chk("starve_last", 32'(u_dut1.starve_cnt_q), 0);
    step(); step(); step(); step();

    // --- latency 4: single load
    d_req4 = 1; d_addr4 = 10'h030;
    settle();
    chk("l4_d_gnt", d_gnt4, 1);
    step(); d_req4 = 0; settle();
    chk("l4_mem_req", mem_req4, 1);
    chk("l4_mem_addr", mem_addr4, 12);
    cnt = 1; mr = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_rsp_valid4) break;
      step(); settle();
      cnt++;
      mr += int'(mem_req4);
    end
    chk("l4_latency", cnt, 6);
    chk("l4_rsp", d_rsp_valid4, 1);
    chk("l4_rdata", d_rsp_rdata4, 32'hCAFEF00D);
    chk("l4_extra_mem_req", mr, 0);

    // --- reset mid-WAIT
    step();
    d_req4 = 1; d_addr4 = 10'h030;
    settle();
    chk("rw_d_gnt", d_gnt4, 1);
    step(); d_req4 = 0;
    step();
    reset = 1;
    settle();
    chk("rw_busy", busy4, 0);
    chk("rw_mem_req", mem_req4, 0);
    chk("rw_d_rdata", d_rsp_rdata4, 0);
    chk("rw_d_rsp", d_rsp_valid4, 0);
    step();
    reset = 0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      pulses += int'(d_rsp_valid4) + int'(i_rsp_valid4) + int'(busy4);
      step();
    end
    chk("rw_no_rsp", pulses, 0);
    i_req4 = 1; i_addr4 = 10'h030;
    settle();
    chk("rw_i_gnt", i_gnt4, 1);
    step(); i_req4 = 0; settle();
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      if (i_rsp_valid4) break;
      step(); settle();
      cnt++;
    end
    chk("rw_latency", cnt, 6);
    chk("rw_rdata", i_rsp_rdata4, 32'hCAFEF00D);
    chk("rw_d_rdata_after", d_rsp_rdata4, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
